bsg_wormhole_output_sched: RTL and testbench

BSG_WORMHOLE_OUTPUT_SCHED -- requirements
Module: bsg_wormhole_output_sched

---
 rtl/bsg_wormhole_output_sched.sv | 110 +++++++++++
 tb/tb_bsg_wormhole_output_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_output_sched.sv
// Wormhole output-port scheduler: round-robin header arbitration, then the output
// stays locked to one input until that packet's tail flit has transferred.
module bsg_wormhole_output_sched #(
    parameter int num_in_p     = 4,
    parameter int flit_width_p = 16,
    parameter int len_width_p  = 4,
    parameter int len_offset_p = 0,
    localparam int ptr_w_lp    = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              v_i,
    input  logic [num_in_p*flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]              yumi_o,
    output logic                             v_o,
    output logic [flit_width_p-1:0]          data_o,
    input  logic                             ready_i,
    output logic [num_in_p-1:0]              grant_o,
    output logic                             busy_o,
    output logic [0:0]                       state_o,
    output logic [ptr_w_lp-1:0]              rr_ptr_o,
    output logic [len_width_p-1:0]           cnt_o
);

    // Handshake: a flit moves when v_o & ready_i; yumi_o is that event routed to
    // the granted input, so an input may only drop a flit after seeing yumi_o.
    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_busy = 1'b1;

    logic [0:0]              state_r;
    logic [ptr_w_lp-1:0]     owner_r, rr_ptr_r, winner, sel;
    logic [len_width_p-1:0]  cnt_r, hdr_len;
    logic [num_in_p-1:0]     sel_onehot;
    logic [flit_width_p-1:0] data_mux;
    logic                    found, any_v, v_raw, xfer;
    int                      idx;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(num_in_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Round-robin search starting at rr_ptr_r, wrapping modulo num_in_p.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < num_in_p; i++) begin
            idx = (int'(rr_ptr_r) + i) % num_in_p;
            if (!found && v_i[ptr_w_lp'(idx)]) begin
                found  = 1'b1;
                winner = ptr_w_lp'(idx);
            end
        end
    end

    assign any_v = |v_i;
    assign sel   = (state_r == st_busy) ? owner_r : winner;

    always_comb begin
        data_mux   = '0;
        sel_onehot = '0;
        for (int k = 0; k < num_in_p; k++) begin
            if (sel == ptr_w_lp'(k)) begin
                data_mux      = data_i[k*flit_width_p +: flit_width_p];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    assign hdr_len = data_mux[len_offset_p +: len_width_p];
    assign v_raw   = (state_r == st_busy) ? v_i[owner_r] : any_v;
    assign v_o     = !reset_i && v_raw;
    assign data_o  = data_mux;
    // While locked the owner keeps its grant even through bubbles.
    assign grant_o = (reset_i || (state_r == st_idle && !any_v)) ? '0 : sel_onehot;
    assign xfer    = v_o && ready_i;
    assign yumi_o  = xfer ? sel_onehot : '0;
    assign busy_o  = (state_r == st_busy);

    assign state_o  = state_r;
    assign rr_ptr_o = rr_ptr_r;
    assign cnt_o    = cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= st_idle;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            cnt_r    <= '0;
        end else if (xfer) begin
            if (state_r == st_idle) begin
                if (hdr_len == '0) begin
                    rr_ptr_r <= next_ptr(winner);
                end else begin
                    state_r <= st_busy;
                    owner_r <= winner;
                    cnt_r   <= hdr_len;
                end
            end else begin
                cnt_r <= cnt_r - len_width_p'(1);
                // Tail flit: release the lock so the next cycle can arbitrate.
                if (cnt_r == len_width_p'(1)) begin
                    state_r  <= st_idle;
                    rr_ptr_r <= next_ptr(owner_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_output_sched.sv
// Bench for bsg_wormhole_output_sched: table vectors, directed lock/backpressure/
// reset sequences, and random traffic against a packet-level reference model.
module tb_bsg_wormhole_output_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int LW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, ready;
    logic [N-1:0]     v;
    logic [W-1:0]     din[N];
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     yumi_o, grant_o;
    logic             v_o, busy_o;
    logic [W-1:0]     data_o;
    logic [0:0]       state_o;
    logic [1:0]       rr_ptr_o;
    logic [LW-1:0]    cnt_o;

    assign data_i = {din[3], din[2], din[1], din[0]};

    bsg_wormhole_output_sched #(
        .num_in_p(N), .flit_width_p(W), .len_width_p(LW), .len_offset_p(0)
    ) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v), .data_i(data_i), .yumi_o(yumi_o),
        .v_o(v_o), .data_o(data_o), .ready_i(ready), .grant_o(grant_o),
        .busy_o(busy_o), .state_o(state_o), .rr_ptr_o(rr_ptr_o), .cnt_o(cnt_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] len;
        logic       ev;
        logic [3:0] eg;
        logic [3:0] ey;
        logic       eb;
        logic [1:0] err;
        logic [3:0] ecnt;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [W-1:0] flit(input int k, input logic [3:0] len);
        return {4'(k), 8'hA5, len};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] vv, input logic rd, input logic [3:0] len);
        rst   = r;
        v     = vv;
        ready = rd;
        for (int k = 0; k < N; k++) din[k] = flit(k, len);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int m_busy, m_owner, m_cnt, m_rr;
    int n_xfer, w, ev, eg, ey, elen, r;

    initial begin
        rst = 1'b1; v = '0; ready = 1'b0;
        for (int k = 0; k < N; k++) din[k] = '0;
        @(negedge clk);

        // rst v rdy len | ev eg ey eb rr cnt
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'd0, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, 4'd0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'd0, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd1, 4'd0};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'd0, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 4'd0};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'd0, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'd3, 4'd0};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'd0, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, 4'd0};
        tbl[6]  = '{1'b0, 4'b0001, 1'b1, 4'd3, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd1, 4'd0};
        tbl[7]  = '{1'b0, 4'b0001, 1'b1, 4'd3, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd1, 4'd3};
        tbl[8]  = '{1'b0, 4'b0001, 1'b1, 4'd3, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd1, 4'd2};
        tbl[9]  = '{1'b0, 4'b0001, 1'b1, 4'd3, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd1, 4'd1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'd0};
        tbl[11] = '{1'b0, 4'b0011, 1'b1, 4'd2, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd1, 4'd0};
        tbl[12] = '{1'b0, 4'b0011, 1'b1, 4'd2, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 4'd2};
        tbl[13] = '{1'b0, 4'b0011, 1'b1, 4'd2, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 4'd1};
        tbl[14] = '{1'b0, 4'b0101, 1'b1, 4'd0, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 4'd0};
        tbl[15] = '{1'b0, 4'b0001, 1'b1, 4'd0, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd3, 4'd0};
        tbl[16] = '{1'b0, 4'b0110, 1'b0, 4'd0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd1, 4'd0};
        tbl[17] = '{1'b1, 4'b1111, 1'b1, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'd0};
        tbl[18] = '{1'b0, 4'b1000, 1'b1, 4'd0, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'd0, 4'd0};

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].rdy, tbl[i].len);
            #1;
            check($sformatf("tbl%0d_v_o", i), 32'(v_o), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_grant", i), 32'(grant_o), 32'(tbl[i].eg));
            check($sformatf("tbl%0d_yumi", i), 32'(yumi_o), 32'(tbl[i].ey));
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].eb));
            check($sformatf("tbl%0d_rr", i), 32'(rr_ptr_o), 32'(tbl[i].err));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt_o), 32'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                for (int k = 0; k < N; k++)
                    if (tbl[i].eg[k]) check($sformatf("tbl%0d_data", i), 32'(data_o), 32'(flit(k, tbl[i].len)));
            end
            tick();
        end

        // Backpressure then bubble in the middle of a len=3 packet from input 2.
        drive(0, 4'b0100, 1, 3); #1;
        check("bp_hdr_yumi", 32'(yumi_o), 32'h4);
        tick();
        drive(0, 4'b0100, 1, 3); #1;
        check("bp_body_yumi", 32'(yumi_o), 32'h4);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b0100, 0, 3); #1;
            check("bp_hold_v_o", 32'(v_o), 32'h1);
            check("bp_hold_grant", 32'(grant_o), 32'h4);
            check("bp_hold_yumi", 32'(yumi_o), 32'h0);
            check("bp_hold_cnt", 32'(cnt_o), 32'h2);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'b0000, 1, 3); #1;
            check("bubble_v_o", 32'(v_o), 32'h0);
            check("bubble_grant", 32'(grant_o), 32'h4);
            check("bubble_yumi", 32'(yumi_o), 32'h0);
            check("bubble_cnt", 32'(cnt_o), 32'h2);
            check("bubble_busy", 32'(busy_o), 32'h1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'b0101, 1, 3); #1;
            check("bp_finish_yumi", 32'(yumi_o), 32'h4);
            tick();
        end
        check("bp_done_busy", 32'(busy_o), 32'h0);
        check("bp_done_rr", 32'(rr_ptr_o), 32'h3);

        // Maximum length packet: header len=15 plus 15 body flits.
        n_xfer = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 4'b0001, 1, 15); #1;
            if (yumi_o[0]) n_xfer++;
            tick();
            if (n_xfer > 0 && !busy_o) break;
        end
        check("maxlen_xfers", 32'(n_xfer), 32'd16);
        check("maxlen_busy", 32'(busy_o), 32'h0);
        check("maxlen_rr", 32'(rr_ptr_o), 32'h1);

        // Reset after 2 of 5 flits of a packet from input 1.
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'b0010, 1, 4); #1;
            check("rstmid_pre_yumi", 32'(yumi_o), 32'h2);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 4'b0010, 1, 4); #1;
            check("rstmid_v_o", 32'(v_o), 32'h0);
            check("rstmid_grant", 32'(grant_o), 32'h0);
            check("rstmid_yumi", 32'(yumi_o), 32'h0);
            tick();
        end
        drive(0, 4'b0000, 1, 0); #1;
        check("rstmid_busy", 32'(busy_o), 32'h0);
        check("rstmid_rr", 32'(rr_ptr_o), 32'h0);
        check("rstmid_cnt", 32'(cnt_o), 32'h0);
        drive(0, 4'b0010, 1, 0); #1;
        check("rstmid_hdr_yumi", 32'(yumi_o), 32'h2);
        tick();
        check("rstmid_hdr_busy", 32'(busy_o), 32'h0);
        check("rstmid_hdr_rr", 32'(rr_ptr_o), 32'h2);

        // Random traffic against a packet-level model.
        m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 2;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            v     = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                r = $urandom_range(0, 9);
                elen = (r < 5) ? 0 : (r < 9) ? $urandom_range(1, 3) : 15;
                din[k] = {12'($urandom), 4'(elen)};
            end
            w = -1;
            if (rst) begin
                ev = 0; eg = 0;
            end else if (m_busy != 0) begin
                w = m_owner; ev = int'(v[m_owner]); eg = 1 << m_owner;
            end else begin
                for (int i = 0; i < N; i++)
                    if (w < 0 && v[(m_rr + i) % N]) w = (m_rr + i) % N;
                ev = (w >= 0) ? 1 : 0;
                eg = (w >= 0) ? (1 << w) : 0;
            end
            ey = (ev != 0 && ready) ? eg : 0;
            #1;
            check($sformatf("rnd%0d_v_o", c), 32'(v_o), 32'(ev));
            check($sformatf("rnd%0d_grant", c), 32'(grant_o), 32'(eg));
            check($sformatf("rnd%0d_yumi", c), 32'(yumi_o), 32'(ey));
            check($sformatf("rnd%0d_busy", c), 32'(busy_o), 32'(m_busy));
            check($sformatf("rnd%0d_rr", c), 32'(rr_ptr_o), 32'(m_rr));
            if (m_busy != 0) check($sformatf("rnd%0d_cnt", c), 32'(cnt_o), 32'(m_cnt));
            if (ev != 0) check($sformatf("rnd%0d_data", c), 32'(data_o), 32'(din[w]));
            if (rst) begin
                m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
            end else if (ey != 0) begin
                if (m_busy != 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 0;
                        m_rr = (m_owner + 1) % N;
                    end
                end else begin
                    elen = int'(din[w][3:0]);
                    if (elen == 0) m_rr = (w + 1) % N;
                    else begin
                        m_busy = 1; m_owner = w; m_cnt = elen;
                    end
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
